// File: rtl/seq_addsub_chunked_if.sv
// rtl/seq_addsub_chunked_if.sv - operand/result bundle for the chunked adder/subtractor
interface seq_addsub_chunked_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output start, sub, a, b, ci,
    input  busy, done, s, co, ovf
  );

  modport slave (
    input  start, sub, a, b, ci,
    output busy, done, s, co, ovf
  );
endinterface

// File: rtl/seq_addsub_chunked.sv
// rtl/seq_addsub_chunked.sv - multi-cycle adder/subtractor, CHUNK bits per clock
// Subtraction is folded into the latch step (b and ci inverted) so RUN only ever adds.
module seq_addsub_chunked #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic            clk,
  input logic            rst,
  seq_addsub_chunked_if.slave bus
);

  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCH        = WIDTH / CHUNK_SAFE;
  localparam int IDXW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK_SAFE{1'b1}});

  generate
    if (CHUNK < 1) begin : g_bad_chunk
      $error("seq_addsub_chunked: CHUNK must be at least 1");
    end else if (WIDTH % CHUNK_SAFE != 0) begin : g_bad_width
      $error("seq_addsub_chunked: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]      ar;
  logic [WIDTH-1:0]      br;
  logic [WIDTH-1:0]      work;
  logic [WIDTH-1:0]      s_r;
  logic                  carry;
  logic                  co_r;
  logic                  ovf_r;
  logic [IDXW-1:0]       idx;

  logic                  last;
  logic [31:0]           base;
  logic [CHUNK_SAFE-1:0] a_chunk;
  logic [CHUNK_SAFE-1:0] b_chunk;
  logic [CHUNK_SAFE:0]   chunk_sum;
  logic [WIDTH-1:0]      work_nxt;
  logic                  ovf_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  // One chunk slice of the adder; the working register collects slices in place.
  always_comb begin
    last      = (idx == IDXW'(NCH - 1));
    base      = 32'(idx) * 32'(CHUNK_SAFE);
    a_chunk   = CHUNK_SAFE'(ar >> base);
    b_chunk   = CHUNK_SAFE'(br >> base);
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK_SAFE{1'b0}}, carry};
    work_nxt  = (work & ~(CMASK << base)) | (WIDTH'(chunk_sum[CHUNK_SAFE-1:0]) << base);
    ovf_nxt   = (ar[WIDTH-1] == br[WIDTH-1]) && (work_nxt[WIDTH-1] != ar[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar    <= '0;
      br    <= '0;
      work  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      s_r   <= '0;
      co_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            ar    <= bus.a;
            br    <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.ci ^ bus.sub;
            work  <= '0;
            idx   <= '0;
          end
        end
        RUN: begin
          work  <= work_nxt;
          carry <= chunk_sum[CHUNK_SAFE];
          if (last) begin
            // Results are published only here, so partial sums never reach the outputs.
            s_r   <= work_nxt;
            co_r  <= chunk_sum[CHUNK_SAFE];
            ovf_r <= ovf_nxt;
            idx   <= '0;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s   = s_r;
  assign bus.co  = co_r;
  assign bus.ovf = ovf_r;

endmodule

// File: doc/seq_addsub_chunked.md
Name: seq_addsub_chunked

Overview:
Parametrised multi-cycle adder/subtractor. It latches two WIDTH-bit operands and processes CHUNK bits per clock, with the carry held in a register between chunks. A start/busy/done handshake controls it, and it reports carry/borrow and signed overflow. Used where a full-width single-cycle carry chain is too slow or too large. It is the clocked, width-generic successor to the 4-bit ripple and behavioural full adders.

Parameters:
WIDTH, 16, operand/result width in bits; must be an exact multiple of CHUNK.
CHUNK, 4, bits added per clock; NCH = WIDTH/CHUNK cycles per operation; CHUNK = WIDTH gives single-cycle operation.

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
sub  input  1  0 = add, 1 = subtract; latched with operands
a  input  WIDTH  operand A; latched on accepted start
b  input  WIDTH  operand B; latched on accepted start
ci  input  1  carry-in (add) / borrow-in (sub); latched on accepted start
busy  output  1  high in RUN and DONE states
done  output  1  one-cycle pulse; s/co/ovf valid from this cycle
s  output  WIDTH  result
co  output  1  carry-out (add); sub: 1 = no borrow, 0 = borrow
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset: rst=1 at a rising edge forces state=IDLE, chunk index=0, internal carry=0, and s=0, co=0, ovf=0, busy=0, done=0. Reset has priority over every other input, including in mid-operation. A reset during RUN abandons the operation; no done pulse is produced.
- Arithmetic:
  - add: {co,s} = a + b + ci.
  - sub: s = a - b - ci, implemented as a + ~b + ~ci.
  - co is the raw carry out of bit WIDTH-1 in both modes.
  - ovf = (A[W-1] == B'[W-1]) && (s[W-1] != A[W-1]), where B' = sub ? ~b : b.
  - All results are modulo 2^WIDTH.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1 at edge E0, latch a, b' (already inverted when sub=1), sub, and initial carry (ci, or ~ci when sub=1). Go to RUN with index=0. busy rises after E0. If start=0, stay in IDLE.
  - RUN: each edge adds chunk[index] of A and B' plus the carry register. The chunk sum goes into the internal working register and the carry register is updated. The edge that processes index NCH-1 goes to DONE and updates s, co and ovf in one step. Otherwise index increments.
  - DONE: done=1 and busy=1 for exactly one cycle. The next edge returns to IDLE and drops busy. A start seen in DONE is ignored and is not queued.
- Latency: done is high in the cycle following edge E0+NCH, i.e. NCH cycles after the accepting edge. The minimum start-to-start spacing is NCH+2 cycles.
- s, co and ovf keep the previous result throughout RUN. Partial sums never appear on the outputs. Results hold after done until the next operation completes.
- start asserted while busy=1 is ignored. Operand and ci changes after the accepting edge have no effect.
- Index wrap: the index never exceeds NCH-1 and is cleared to 0 on acceptance.
- Elaboration must fail if WIDTH % CHUNK != 0 or CHUNK < 1.

Test Plan:
- Reset: hold rst 2 cycles with arbitrary inputs -> s=0, co=0, ovf=0, busy=0, done=0. With WIDTH=16 and CHUNK=4, a start in the first cycle after reset is accepted.
- Add wrap: a=0xFFFF, b=0x0001, ci=0, sub=0 -> done exactly 4 cycles after the accept edge; s=0x0000, co=1, ovf=0. With ci=1 -> s=0x0001, co=1.
- Signed overflow add: a=0x7FFF, b=0x0001 -> s=0x8000, co=0, ovf=1. Subtract: a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, co=1, ovf=1. Subtract with borrow: a=0x0005, b=0x0007 -> s=0xFFFE, co=0, ovf=0.
- Busy protection: start a=0x1234, b=0x1111. Pulse start with a=0xFFFF, b=0xFFFF in RUN cycle 2 and again in the DONE cycle -> single done pulse, s=0x2345. The next IDLE start is accepted normally. s holds its old value throughout RUN.
- Mid-op reset: assert rst on RUN cycle 2 -> all outputs 0 next cycle and no done ever appears. A following start with a=0x0003, b=0x0004 gives s=0x0007 on schedule.
- Parameter sweep: CHUNK=16 (done 1 cycle after accept) and CHUNK=1 (16 cycles). Run 1000 random a/b/ci/sub each against the {co,s} reference model -> all match.
